// File: rtl/ins_fetcher_if.sv
// Fetch-unit bus bundle: memory request/response, decoder head port and ROB redirect.
// master = fetch unit side, slave = environment (memory, decoder, ROB) side.
interface ins_fetcher_if;
  logic        fetch2mem_req;
  logic [31:0] fetch2mem_addr;
  logic        mem2fetch_valid;
  logic [31:0] mem2fetch_ins;
  logic        fetch2decoder_valid;
  logic [31:0] fetch2decoder_ins;
  logic [31:0] fetch2decoder_pc;
  logic        decoder2fetch_ready;
  logic        ROB2fetch_redirect;
  logic [31:0] ROB2fetch_target;

  modport master (
    output fetch2mem_req, fetch2mem_addr,
    output fetch2decoder_valid, fetch2decoder_ins, fetch2decoder_pc,
    input  mem2fetch_valid, mem2fetch_ins,
    input  decoder2fetch_ready, ROB2fetch_redirect, ROB2fetch_target
  );

  modport slave (
    input  fetch2mem_req, fetch2mem_addr,
    input  fetch2decoder_valid, fetch2decoder_ins, fetch2decoder_pc,
    output mem2fetch_valid, mem2fetch_ins,
    output decoder2fetch_ready, ROB2fetch_redirect, ROB2fetch_target
  );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetch front end: single outstanding memory fetch, circular instruction
// queue toward the decoder, static JAL-taken prediction and ROB redirect/flush.
//
// state    | meaning
// IDLE     | no fetch outstanding; issue one when the queue has room
// WAIT_MEM | fetch outstanding; response is pushed into the queue
// DROP     | fetch outstanding but made stale by a redirect; response discarded
module ins_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  ins_fetcher_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DROP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [31:0]        ins_mem_q [DEPTH];
  logic [31:0]        pc_mem_q  [DEPTH];

  logic               push, pop;
  logic [31:0]        jal_imm, next_pc;

  // JAL immediate: imm[20|10:1|11|19:12] scattered across ins[31:12]
  assign jal_imm = {{11{bus.mem2fetch_ins[31]}}, bus.mem2fetch_ins[31],
                    bus.mem2fetch_ins[19:12], bus.mem2fetch_ins[20],
                    bus.mem2fetch_ins[30:21], 1'b0};
  assign next_pc = (bus.mem2fetch_ins[6:0] == 7'b1101111) ? pc_q + jal_imm
                                                         : pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push    = 1'b0;
    pop     = (count_q != '0) && bus.decoder2fetch_ready && !bus.ROB2fetch_redirect;

    case (state_q)
      IDLE: begin
        if (!bus.ROB2fetch_redirect && (count_q < CNT_FULL)) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (bus.mem2fetch_valid) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!bus.ROB2fetch_redirect) begin
            push = 1'b1;
            pc_d = next_pc;
          end
        end else if (bus.ROB2fetch_redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem2fetch_valid) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.ROB2fetch_redirect) begin
      pc_d    = bus.ROB2fetch_target;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        ins_mem_q[tail_q] <= bus.mem2fetch_ins;
        pc_mem_q[tail_q]  <= pc_q;
      end
    end
  end

  assign bus.fetch2mem_req       = req_q;
  assign bus.fetch2mem_addr      = addr_q;
  assign bus.fetch2decoder_valid = (count_q != '0);
  assign bus.fetch2decoder_ins   = ins_mem_q[head_q];
  assign bus.fetch2decoder_pc    = pc_mem_q[head_q];
endmodule
